// File: rtl/permutation_ctrl.sv
// rtl/permutation_ctrl.sv - ASCON permutation sequencer: state register, round index, p12/short control
module permutation_ctrl #(
    parameter int NB_ROUNDS_SHORT = 6
) (
    input  logic             clock_i,
    input  logic             resetb_i,
    input  logic             start_i,
    input  logic             mode_i,
    input  logic [4:0][63:0] state_i,
    input  logic [4:0][63:0] round_state_i,
    output logic [3:0]       round_o,
    output logic [4:0][63:0] state_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    localparam logic [3:0] SHORT_START = 4'(12 - NB_ROUNDS_SHORT);
    localparam logic [3:0] LAST_ROUND  = 4'd11;

    fsm_t             fsm;
    logic [3:0]       round;
    logic [4:0][63:0] state_reg;
    logic             busy;
    logic             done;

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            fsm       <= IDLE;
            round     <= 4'd0;
            state_reg <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    round <= 4'd0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    if (start_i) begin
                        state_reg <= state_i;
                        round     <= mode_i ? SHORT_START : 4'd0;
                        busy      <= 1'b1;
                        fsm       <= RUN;
                    end
                end
                RUN: begin
                    // 12..15 cannot occur in normal operation; abandon the run rather than wrap
                    if (round > LAST_ROUND) begin
                        round <= 4'd0;
                        busy  <= 1'b0;
                        fsm   <= IDLE;
                    end else begin
                        state_reg <= round_state_i;
                        if (round == LAST_ROUND) begin
                            done <= 1'b1;
                            fsm  <= DONE;
                        end else begin
                            round <= round + 4'd1;
                        end
                    end
                end
                DONE: begin
                    round <= 4'd0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    fsm   <= IDLE;
                end
                default: begin
                    round <= 4'd0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    fsm   <= IDLE;
                end
            endcase
        end
    end

    assign round_o = round;
    assign state_o = state_reg;
    assign busy_o  = busy;
    assign done_o  = done;

endmodule

// File: tb/tb_permutation_ctrl.sv
// tb/tb_permutation_ctrl.sv - directed bench for permutation_ctrl with stub round datapath
module tb_permutation_ctrl;

    logic             clk = 1'b0;
    logic             rstb = 1'b0;
    logic             start = 1'b0;
    logic             mode = 1'b0;
    logic [4:0][63:0] st_in = '0;
    logic [4:0][63:0] rnd_st;
    logic [4:0][63:0] st_out;
    logic [3:0]       rnd;
    logic             busy;
    logic             done;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    // stub datapath: word 2 low byte XOR ASCON round constant {~r, r}
    always_comb begin
        rnd_st = st_out;
        rnd_st[2][7:0] = st_out[2][7:0] ^ {4'hF - rnd, rnd};
    end

    permutation_ctrl dut (
        .clock_i      (clk),
        .resetb_i     (rstb),
        .start_i      (start),
        .mode_i       (mode),
        .state_i      (st_in),
        .round_state_i(rnd_st),
        .round_o      (rnd),
        .state_o      (st_out),
        .busy_o       (busy),
        .done_o       (done)
    );

    task automatic test_reset();
        logic [4:0][63:0] junk;
        junk = '0;
        junk[0] = 64'hDEAD_BEEF_0000_0001;
        rstb = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; mode = 1'b0; st_in = junk;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        total++; if (rnd !== 4'd0) begin bad++; $display("FAIL reset_round got=%0d exp=0", rnd); end
        total++; if (st_out !== '0) begin bad++; $display("FAIL reset_state got=%h exp=0", st_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        rstb = 1'b1;
        @(negedge clk);
        total++; if (busy !== 1'b0 || st_out !== '0) begin bad++; $display("FAIL reset_release busy=%b state=%h exp idle/0", busy, st_out); end
    endtask

    task automatic test_p12();
        st_in = '0; mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            total++; if (rnd !== 4'(k) || busy !== 1'b1 || done !== 1'b0) begin
                bad++; $display("FAIL p12_step%0d round=%0d busy=%b done=%b exp round=%0d busy=1 done=0", k, rnd, busy, done, k);
            end
            @(negedge clk);
        end
        total++; if (done !== 1'b1 || rnd !== 4'd11) begin bad++; $display("FAIL p12_done done=%b round=%0d exp 1/11", done, rnd); end
        total++; if (st_out !== '0) begin bad++; $display("FAIL p12_state got=%h exp=0", st_out); end
        @(negedge clk);
        total++; if (done !== 1'b0 || busy !== 1'b0 || rnd !== 4'd0) begin
            bad++; $display("FAIL p12_after done=%b busy=%b round=%0d exp 0/0/0", done, busy, rnd);
        end
    endtask

    task automatic test_short();
        logic [4:0][63:0] exp_st;
        st_in = '0; st_in[2] = 64'hFF; mode = 1'b1; start = 1'b1;
        exp_st = '0; exp_st[2] = 64'hEE;
        @(negedge clk);
        start = 1'b0; mode = 1'b0;
        for (int k = 6; k < 12; k++) begin
            total++; if (rnd !== 4'(k) || done !== 1'b0) begin
                bad++; $display("FAIL short_step round=%0d done=%b exp round=%0d done=0", rnd, done, k);
            end
            @(negedge clk);
        end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL short_latency done=%b exp=1 at cycle 7", done); end
        total++; if (st_out !== exp_st) begin bad++; $display("FAIL short_state got=%h exp=%h", st_out, exp_st); end
        @(negedge clk);
        total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL short_after done=%b busy=%b exp 0/0", done, busy); end
    endtask

    task automatic test_start_while_busy();
        logic [4:0][63:0] init_st;
        init_st = '0;
        init_st[0] = 64'h0123_4567_89AB_CDEF;
        init_st[2] = 64'hA5;
        init_st[4] = 64'hFEDC_BA98_7654_3210;
        st_in = init_st; mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            total++; if (rnd !== 4'(k) || done !== 1'b0) begin
                bad++; $display("FAIL busy_step round=%0d done=%b exp round=%0d done=0", rnd, done, k);
            end
            if (k == 5) begin
                start = 1'b1; mode = 1'b1; st_in = '1;
            end else begin
                start = 1'b0; mode = 1'b0; st_in = '0;
            end
            @(negedge clk);
        end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL busy_latency done=%b exp=1", done); end
        total++; if (st_out !== init_st) begin bad++; $display("FAIL busy_state got=%h exp=%h", st_out, init_st); end
        start = 1'b1; mode = 1'b1; st_in = '1;
        @(negedge clk);
        start = 1'b0; st_in = '0; mode = 1'b0;
        total++; if (busy !== 1'b0 || done !== 1'b0 || st_out !== init_st) begin
            bad++; $display("FAIL busy_done_start busy=%b done=%b state=%h exp idle, held", busy, done, st_out);
        end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_queued busy=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid();
        int n;
        st_in = '0; st_in[1] = 64'h55; mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (rnd !== 4'd4 && n < 20) begin @(negedge clk); n++; end
        total++; if (rnd !== 4'd4) begin bad++; $display("FAIL midrst_wait round=%0d exp=4", rnd); end
        #1 rstb = 1'b0;
        #1;
        total++; if (rnd !== 4'd0 || st_out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL midrst_async round=%0d state=%h busy=%b done=%b exp all 0", rnd, st_out, busy, done);
        end
        @(negedge clk);
        rstb = 1'b1;
        st_in = '0; mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            total++; if (rnd !== 4'(k) || done !== 1'b0) begin
                bad++; $display("FAIL midrst_step round=%0d done=%b exp round=%0d done=0", rnd, done, k);
            end
            @(negedge clk);
        end
        total++; if (done !== 1'b1 || st_out !== '0) begin bad++; $display("FAIL midrst_done done=%b state=%h exp 1/0", done, st_out); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic exp_done;
        logic exp_busy;
        st_in = '0; mode = 1'b0; start = 1'b1;
        for (int c = 1; c <= 42; c++) begin
            @(negedge clk);
            exp_done = ((c % 14) == 13);
            exp_busy = ((c % 14) != 0);
            total++; if (done !== exp_done || busy !== exp_busy) begin
                bad++; $display("FAIL b2b_cycle%0d done=%b busy=%b exp done=%b busy=%b", c, done, busy, exp_done, exp_busy);
            end
            if (exp_done) begin
                total++; if (st_out !== '0) begin bad++; $display("FAIL b2b_state cycle%0d got=%h exp=0", c, st_out); end
            end
        end
        start = 1'b0;
        repeat (16) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_stop busy=%b exp=0", busy); end
    endtask

    initial begin
        test_reset();
        test_p12();
        test_short();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
